// File: rtl/bias_ctrl_if.sv
// Bias controller bus: load stream, run control, activation stream
// and the registered drive into the bias adder.
interface bias_ctrl_if #(
  parameter int DEPTH = 4,
  parameter int ROWW  = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic            load_start;
  logic [LW-1:0]   load_len;
  logic            load_valid;
  logic [15:0]     load_data;
  logic            load_ready;
  logic            run_start;
  logic [ROWW-1:0] run_rows;
  logic            in_valid;
  logic [15:0]     in_data;
  logic            bias_valid_in;
  logic [15:0]     input_in;
  logic [15:0]     bias_in;
  logic            busy;
  logic            done;
  logic            err;

  modport master (
    output load_start, load_len, load_valid, load_data,
    output run_start, run_rows, in_valid, in_data,
    input  load_ready, bias_valid_in, input_in, bias_in,
    input  busy, done, err
  );

  modport slave (
    input  load_start, load_len, load_valid, load_data,
    input  run_start, run_rows, in_valid, in_data,
    output load_ready, bias_valid_in, input_in, bias_in,
    output busy, done, err
  );
endinterface

// File: rtl/bias_ctrl.sv
// Bias-vector store and per-element bias issue to the adder unit.
// Define BIAS_CTRL_ERR_EN to build the sticky protocol-error flag.
module bias_ctrl #(
  parameter int DEPTH = 4,
  parameter int ROWW  = 8
) (
  input logic       clk,
  input logic       rst,
  bias_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0]   L1 = LW'(1);
  localparam logic [AW-1:0]   A1 = AW'(1);
  localparam logic [ROWW-1:0] R1 = ROWW'(1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    READY,
    RUN
  } state_t;

  state_t state, state_nx;

  logic [LW-1:0]   len;
  logic [AW-1:0]   wi;
  logic [AW-1:0]   ei;
  logic [ROWW-1:0] rc;
  logic [ROWW-1:0] rows;
  logic [15:0]     mem [DEPTH];

  logic        bv_q;
  logic [15:0] in_q;
  logic [15:0] bias_q;
  logic        done_q;

  logic len_ok;
  logic go_load;
  logic ld_acc;
  logic wr_last;
  logic go_run;
  logic zero_run;
  logic el_acc;
  logic el_wrap;
  logic el_last;

  assign len_ok = (bus.load_len != '0) &&
                  (bus.load_len <= LW'(DEPTH));

  assign go_load = bus.load_start && len_ok &&
                   (state == IDLE || state == READY);

  assign ld_acc  = (state == LOAD) && bus.load_valid;
  assign wr_last = ld_acc && (LW'(wi) == len - L1);

  // load_start takes priority over run_start in READY
  assign go_run   = (state == READY) && !bus.load_start &&
                    bus.run_start && (bus.run_rows != '0);
  assign zero_run = (state == READY) && !bus.load_start &&
                    bus.run_start && (bus.run_rows == '0);

  assign el_acc  = (state == RUN) && bus.in_valid;
  assign el_wrap = (LW'(ei) == len - L1);
  assign el_last = el_acc && el_wrap && (rc == rows - R1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (go_load) state_nx = LOAD;
      LOAD:    if (wr_last) state_nx = READY;
      READY: begin
        if (go_load)     state_nx = LOAD;
        else if (go_run) state_nx = RUN;
      end
      RUN:     if (el_last) state_nx = READY;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len    <= '0;
      wi     <= '0;
      ei     <= '0;
      rc     <= '0;
      rows   <= '0;
      bv_q   <= 1'b0;
      in_q   <= '0;
      bias_q <= '0;
      done_q <= 1'b0;
    end else begin
      if (go_load) begin
        len <= bus.load_len;
        wi  <= '0;
      end else if (ld_acc) begin
        wi <= wi + A1;
      end
      if (go_run) begin
        ei   <= '0;
        rc   <= '0;
        rows <= bus.run_rows;
      end else if (el_acc) begin
        if (el_wrap) begin
          ei <= '0;
          rc <= rc + R1;
        end else begin
          ei <= ei + A1;
        end
      end
      bv_q   <= el_acc;
      in_q   <= el_acc ? bus.in_data : '0;
      bias_q <= el_acc ? mem[ei] : '0;
      done_q <= el_last || zero_run;
    end
  end

  // storage is deliberately unreset; READY needs a full load first
  always_ff @(posedge clk) begin
    if (ld_acc) mem[wi] <= bus.load_data;
  end

  assign bus.load_ready    = (state == LOAD);
  assign bus.busy          = (state == LOAD) || (state == RUN);
  assign bus.bias_valid_in = bv_q;
  assign bus.input_in      = in_q;
  assign bus.bias_in       = bias_q;
  assign bus.done          = done_q;

`ifdef BIAS_CTRL_ERR_EN
  logic err_q;
  logic err_hit;

  assign err_hit =
    (bus.in_valid && state != RUN) ||
    (bus.load_start && (state == LOAD || state == RUN)) ||
    (bus.run_start && state != READY) ||
    (bus.load_start && !len_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_q | err_hit;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif
endmodule
